// File: rtl/output_interface_pkg.sv
// Shared port encodings and helpers for the router output port.
package output_interface_pkg;

  localparam int unsigned NUM_PORTS      = 5;
  localparam int unsigned PORT_IDX_W     = 3;
  localparam int unsigned DATA_WIDTH_DEF = 64;

  typedef logic [NUM_PORTS-1:0]  port_vec_t;
  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  // One-hot direction codes; bit 4 is L, bit 0 is PE
  localparam port_vec_t DIR_L  = 5'b10000;
  localparam port_vec_t DIR_R  = 5'b01000;
  localparam port_vec_t DIR_U  = 5'b00100;
  localparam port_vec_t DIR_D  = 5'b00010;
  localparam port_vec_t DIR_PE = 5'b00001;

  function automatic port_idx_t onehot_to_idx(input port_vec_t v);
    port_idx_t idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (v[i]) idx = PORT_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/output_interface_rr_arbiter5.sv
// Five-way round-robin arbiter; search starts just after ptr and walks L->R->U->D->PE->L.
module rr_arbiter5
  import output_interface_pkg::*;
(
  input  port_vec_t req,
  input  logic      en,
  input  port_vec_t ptr,
  output port_vec_t gnt
);

  port_idx_t ptr_idx;
  port_idx_t cand;
  logic      found;

  // Descending bit index is the circular priority order, wrapping PE(0) back to L(4)
  always_comb begin
    gnt     = '0;
    found   = 1'b0;
    cand    = '0;
    ptr_idx = onehot_to_idx(ptr);
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      if (32'(ptr_idx) >= k) begin
        cand = PORT_IDX_W'(32'(ptr_idx) - k);
      end else begin
        cand = PORT_IDX_W'(32'(ptr_idx) + NUM_PORTS - k);
      end
      if (en && !found && req[cand]) begin
        gnt[cand] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_interface.sv
// Router output port: arbitrates the five input buffers, queues the winner's flit,
// and drives it to the neighbour under its ready.
module output_interface
  import output_interface_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter port_vec_t   DIRECTION    = DIR_L,
  parameter int unsigned BUFFER_DEPTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            req_in,
  input  logic [DATA_WIDTH-1:0] dataiL,
  input  logic [DATA_WIDTH-1:0] dataiR,
  input  logic [DATA_WIDTH-1:0] dataiU,
  input  logic [DATA_WIDTH-1:0] dataiD,
  input  logic [DATA_WIDTH-1:0] dataiPE,
  output logic [4:0]            buf_clear,
  output logic                  so,
  output logic [DATA_WIDTH-1:0] datao,
  input  logic                  ro
);

  localparam int unsigned CNT_W = $clog2(BUFFER_DEPTH + 1);
  localparam int unsigned IDX_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;

  logic [CNT_W-1:0]      count_q;
  logic [IDX_W-1:0]      head_q;
  logic [IDX_W-1:0]      tail_q;
  logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
  port_vec_t             ptr_q;
  port_vec_t             req_masked;
  port_vec_t             gnt;
  logic                  pop;
  logic                  push;
  logic                  space;
  logic [DATA_WIDTH-1:0] push_data;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(BUFFER_DEPTH - 1)) ? '0 : i + 1'b1;
  endfunction

  // A request from our own direction would be a U-turn
  assign req_masked = req_in & ~DIRECTION;
  assign pop        = so & ro;
  assign space      = (count_q < CNT_W'(BUFFER_DEPTH)) | pop;

  // Reset gates the grant so buf_clear is quiet while rst is low
  rr_arbiter5 u_arb (
    .req (req_masked),
    .en  (space & rst),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  assign buf_clear = gnt;
  assign push      = |gnt;
  assign so        = (count_q != '0);
  assign datao     = mem_q[head_q];

  // One-hot AND-OR select of the winning source's flit
  always_comb begin
    push_data = '0;
    push_data = push_data | ({DATA_WIDTH{|(gnt & DIR_L)}}  & dataiL);
    push_data = push_data | ({DATA_WIDTH{|(gnt & DIR_R)}}  & dataiR);
    push_data = push_data | ({DATA_WIDTH{|(gnt & DIR_U)}}  & dataiU);
    push_data = push_data | ({DATA_WIDTH{|(gnt & DIR_D)}}  & dataiD);
    push_data = push_data | ({DATA_WIDTH{|(gnt & DIR_PE)}} & dataiPE);
  end

  // Ring buffer: when full, a same-edge pop frees the slot the push lands in
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      ptr_q   <= DIR_PE;
      for (int unsigned i = 0; i < BUFFER_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[tail_q] <= push_data;
        tail_q        <= next_idx(tail_q);
        ptr_q         <= gnt;
      end
      if (pop) begin
        head_q <= next_idx(head_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_output_interface.sv
// Bench for output_interface: two instances (depth 1 and depth 2) against a queue-based model.
module tb_output_interface;

  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    req_in;
  logic          ro;
  logic [DW-1:0] din [5];
  logic [4:0]    bc [2];
  logic          so_o [2];
  logic [DW-1:0] dat [2];

  always #5 clk = ~clk;

  output_interface #(.DATA_WIDTH(DW), .DIRECTION(5'b00010), .BUFFER_DEPTH(1)) dut_a (
    .clk(clk), .rst(rst), .req_in(req_in),
    .dataiL(din[0]), .dataiR(din[1]), .dataiU(din[2]), .dataiD(din[3]), .dataiPE(din[4]),
    .buf_clear(bc[0]), .so(so_o[0]), .datao(dat[0]), .ro(ro)
  );

  output_interface #(.DATA_WIDTH(DW), .DIRECTION(5'b10000), .BUFFER_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .req_in(req_in),
    .dataiL(din[0]), .dataiR(din[1]), .dataiU(din[2]), .dataiD(din[3]), .dataiPE(din[4]),
    .buf_clear(bc[1]), .so(so_o[1]), .datao(dat[1]), .ro(ro)
  );

  // Reference model: one FIFO queue per instance, RR pointer as position 0..4 (L..PE)
  logic [DW-1:0] mq0[$];
  logic [DW-1:0] mq1[$];
  int            mptr [2];
  int            mdep [2];
  logic [4:0]    mdir [2];
  logic [4:0]    last_bc [2];
  int            n_vec = 0;
  int            n_err = 0;

  function automatic int qsize(input int i);
    return (i == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [DW-1:0] qhead(input int i);
    if (i == 0) return mq0[0];
    return mq1[0];
  endfunction

  function automatic int onehot_pos(input logic [4:0] v);
    for (int p = 0; p < 5; p++) begin
      if (v == (5'b10000 >> p)) return p;
    end
    return 0;
  endfunction

  // Grant the first requester after the pointer in L,R,U,D,PE order, if there is room
  function automatic logic [4:0] exp_grant(input int i);
    logic [4:0] bitv;
    int         p;
    bit         pop;
    if (rst !== 1'b1) return 5'b0;
    pop = (qsize(i) > 0) && (ro === 1'b1);
    if (!((qsize(i) < mdep[i]) || pop)) return 5'b0;
    for (int k = 1; k <= 5; k++) begin
      p    = (mptr[i] + k) % 5;
      bitv = 5'b10000 >> p;
      if ((req_in & ~mdir[i] & bitv) != 5'b0) return bitv;
    end
    return 5'b0;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check at the falling edge, then advance the model on the rising edge
  task automatic cycle();
    logic [4:0] g [2];
    bit         pop [2];
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      g[i]       = exp_grant(i);
      pop[i]     = (rst === 1'b1) && (qsize(i) > 0) && (ro === 1'b1);
      last_bc[i] = bc[i];
      chk($sformatf("buf_clear[%0d]", i), DW'(bc[i]), DW'(g[i]));
      chk($sformatf("so[%0d]", i), DW'(so_o[i]), DW'(qsize(i) > 0));
      if (qsize(i) > 0) chk($sformatf("datao[%0d]", i), dat[i], qhead(i));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (pop[i]) begin
        if (i == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
      end
      if (g[i] != 5'b0) begin
        if (i == 0) mq0.push_back(din[onehot_pos(g[i])]);
        else        mq1.push_back(din[onehot_pos(g[i])]);
        mptr[i] = onehot_pos(g[i]);
      end
    end
    #1;
  endtask

  // Assert reset between edges and check outputs fall immediately
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_so[%0d]", i), DW'(so_o[i]), '0);
      chk($sformatf("rst_datao[%0d]", i), dat[i], '0);
      chk($sformatf("rst_bc[%0d]", i), DW'(bc[i]), '0);
    end
    mq0.delete();
    mq1.delete();
    mptr[0] = 4;
    mptr[1] = 4;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] rr_exp [4];
    rr_exp[0] = 5'b10000; rr_exp[1] = 5'b01000; rr_exp[2] = 5'b00100; rr_exp[3] = 5'b00001;
    mdep[0] = 1;        mdep[1] = 2;
    mdir[0] = 5'b00010; mdir[1] = 5'b10000;
    mptr[0] = 4;        mptr[1] = 4;
    rst = 1'b1; req_in = 5'b0; ro = 1'b0;
    for (int p = 0; p < 5; p++) din[p] = '0;

    // Power-on reset; requests held high must not produce a grant
    #1 rst = 1'b0;
    req_in = 5'b11111;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("por_so", DW'(so_o[i]), '0);
      chk("por_datao", dat[i], '0);
      chk("por_bc", DW'(bc[i]), '0);
    end
    @(posedge clk); #1;
    rst = 1'b1; req_in = 5'b0;

    // Single flit from U
    req_in = 5'b00100; din[2] = 64'hA5; ro = 1'b1;
    cycle();
    chk("single_bc", DW'(last_bc[0]), DW'(5'b00100));
    req_in = 5'b0;
    chk("single_so", DW'(so_o[0]), 64'd1);
    chk("single_datao", dat[0], 64'hA5);
    cycle();
    chk("single_drained", DW'(so_o[0]), '0);

    // Reset mid-run with one flit buffered
    ro = 1'b0; req_in = 5'b00100; din[2] = 64'h1234;
    cycle();
    req_in = 5'b0;
    do_reset();

    // Round-robin with all requests held; A skips its own D direction
    req_in = 5'b11111; ro = 1'b1;
    for (int n = 0; n < 8; n++) begin
      din[0] = 64'h100 + 64'(n); din[1] = 64'h200 + 64'(n); din[2] = 64'h300 + 64'(n);
      din[3] = 64'h400 + 64'(n); din[4] = 64'h500 + 64'(n);
      cycle();
      chk("rr_order", DW'(last_bc[0]), DW'(rr_exp[n % 4]));
      chk("rr_onehot", DW'($onehot(last_bc[1])), 64'd1);
    end
    req_in = 5'b0;
    do_reset();

    // Backpressure on the depth-1 instance
    ro = 1'b0; req_in = 5'b11000; din[0] = 64'hAAAA_0001; din[1] = 64'hBBBB_0002;
    cycle();
    chk("bp_first", DW'(last_bc[0]), DW'(5'b10000));
    req_in = 5'b01000;
    for (int n = 0; n < 3; n++) begin
      cycle();
      chk("bp_blocked", DW'(last_bc[0]), '0);
      chk("bp_stable", dat[0], 64'hAAAA_0001);
    end
    ro = 1'b1;
    cycle();
    chk("bp_second", DW'(last_bc[0]), DW'(5'b01000));
    req_in = 5'b0;
    chk("bp_newhead", dat[0], 64'hBBBB_0002);
    cycle();
    do_reset();

    // Depth-2 fill, then one pop+push, FIFO order on B
    ro = 1'b0; din[1] = 64'h11; din[2] = 64'h22; din[3] = 64'h33;
    req_in = 5'b01110; cycle();
    req_in = 5'b00110; cycle();
    req_in = 5'b00010; cycle();
    chk("full_nogrant", DW'(last_bc[1]), '0);
    ro = 1'b1; cycle();
    chk("full_swap_grant", DW'(last_bc[1]), DW'(5'b00010));
    ro = 1'b0; req_in = 5'b0;
    chk("fifo_head", dat[1], 64'h22);
    cycle();
    ro = 1'b1;
    repeat (3) cycle();
    do_reset();

    // Own direction only: A never grants
    req_in = 5'b00010; ro = 1'b1;
    for (int n = 0; n < 10; n++) begin
      cycle();
      chk("self_so", DW'(so_o[0]), '0);
      chk("self_bc", DW'(last_bc[0]), '0);
    end
    req_in = 5'b0;

    // Random traffic with occasional resets
    for (int n = 0; n < 500; n++) begin
      req_in = 5'($urandom_range(0, 31));
      ro     = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < 5; p++) din[p] = {$urandom, $urandom};
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
